// File: rtl/mul_fu_pkg.sv
// Shared out-of-order core definitions used by the MUL functional unit:
// datapath widths, RV32M funct3 encodings, stage payload and operand extension.
package ooo_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // Control payload that travels alongside the data through every stage.
  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [TAG_W-1:0] prd;
    logic [2:0]       f3;
  } stage_t;

  // Widen an operand by one bit so signed and unsigned forms can share
  // a single signed multiplier.
  function automatic logic [XLEN:0] ext33(input logic [XLEN-1:0] v, input logic sgn);
    return {sgn & v[XLEN-1], v};
  endfunction

endpackage

// File: rtl/mul_fu_if.sv
// Issue-side and CDB-side signals of the MUL unit.
// The master side (RS + CDB arbiter) drives issue and grant; the slave side is the unit.
interface mul_fu_if import ooo_pkg::*; ();

  logic             mul_request_i;
  logic [31:0]      mul_pc_i;
  logic [31:0]      mul_inst_i;
  logic [TAG_W-1:0] mul_prs1_addr_i;
  logic [TAG_W-1:0] mul_prs2_addr_i;
  logic [TAG_W-1:0] mul_prd_addr_i;
  logic [XLEN-1:0]  rs1_data_i;
  logic [XLEN-1:0]  rs2_data_i;
  logic             mul_ready_o;

  logic             cdb_req_o;
  logic             cdb_grant_i;
  logic [TAG_W-1:0] cdb_tag_o;
  logic [XLEN-1:0]  cdb_data_o;
  logic [31:0]      cdb_pc_o;

  modport master (
    output mul_request_i, mul_pc_i, mul_inst_i,
           mul_prs1_addr_i, mul_prs2_addr_i, mul_prd_addr_i,
           rs1_data_i, rs2_data_i, cdb_grant_i,
    input  mul_ready_o, cdb_req_o, cdb_tag_o, cdb_data_o, cdb_pc_o
  );

  modport slave (
    input  mul_request_i, mul_pc_i, mul_inst_i,
           mul_prs1_addr_i, mul_prs2_addr_i, mul_prd_addr_i,
           rs1_data_i, rs2_data_i, cdb_grant_i,
    output mul_ready_o, cdb_req_o, cdb_tag_o, cdb_data_o, cdb_pc_o
  );

endinterface

// File: rtl/mul_fu_core.sv
// Pure combinational 33x33 signed multiplier. Kept as its own module so a
// multi-cycle or hard-macro implementation can replace it without touching
// the pipeline control.
module mul_core import ooo_pkg::*; (
  input  logic [XLEN:0]     i_a,
  input  logic [XLEN:0]     i_b,
  output logic [2*XLEN+1:0] o_prod
);

  // Operands are sign-extended to the 66-bit result width before multiplying.
  assign o_prod = $signed(i_a) * $signed(i_b);

endmodule

// File: rtl/mul_fu.sv
// Three-stage RV32M multiply unit: S1 captures and extends operands, S2 holds
// the full product, S3 holds the selected word until the CDB grants it.
// Stages advance independently so bubbles collapse under backpressure.
module mul_fu import ooo_pkg::*; (
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     flush_i,
  mul_fu_if.slave  mul_if
);

  stage_t            r_s1, r_s2, r_s3;
  logic [XLEN:0]     r_s1_a, r_s1_b;
  logic [2*XLEN-1:0] r_s2_prod;
  logic [XLEN-1:0]   r_s3_data;

  logic [2*XLEN+1:0] w_prod;
  logic [2:0]        w_f3;
  logic              w_signed_a, w_signed_b;
  logic              w_s3_free, w_s2_free, w_s1_free, w_accept;
  logic              w_unused;

  assign w_f3       = mul_if.mul_inst_i[14:12];
  assign w_signed_a = (w_f3[1:0] == F3_MULH[1:0]) || (w_f3[1:0] == F3_MULHSU[1:0]);
  assign w_signed_b = (w_f3[1:0] == F3_MULH[1:0]);

  // A stage can load when it is empty or its contents move on this edge;
  // the chain reaches back through cdb_grant_i to the issue port.
  assign w_s3_free = ~r_s3.valid | mul_if.cdb_grant_i;
  assign w_s2_free = ~r_s2.valid | w_s3_free;
  assign w_s1_free = ~r_s1.valid | w_s2_free;
  assign w_accept  = mul_if.mul_request_i & w_s1_free;

  assign mul_if.mul_ready_o = w_s1_free;

  // S1: capture issue payload and the extended operands.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor; the later flush assignment wins.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1   <= '0;
      r_s1_a <= '0;
      r_s1_b <= '0;
    end else begin
      if (w_s1_free) begin
        r_s1.valid <= w_accept;
        r_s1.pc    <= mul_if.mul_pc_i;
        r_s1.prd   <= mul_if.mul_prd_addr_i;
        r_s1.f3    <= w_f3;
        r_s1_a     <= ext33(mul_if.rs1_data_i, w_signed_a);
        r_s1_b     <= ext33(mul_if.rs2_data_i, w_signed_b);
      end
      if (flush_i) r_s1.valid <= 1'b0;
    end
  end

  mul_core u_mul_core (
    .i_a    (r_s1_a),
    .i_b    (r_s1_b),
    .o_prod (w_prod)
  );

  // S2: register the product; only the low 64 bits carry architectural data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s2      <= '0;
      r_s2_prod <= '0;
    end else begin
      if (w_s2_free) begin
        r_s2      <= r_s1;
        r_s2_prod <= w_prod[2*XLEN-1:0];
      end
      if (flush_i) r_s2.valid <= 1'b0;
    end
  end

  // S3: select low or high word and hold it until the CDB grants.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s3      <= '0;
      r_s3_data <= '0;
    end else begin
      if (w_s3_free) begin
        r_s3      <= r_s2;
        r_s3_data <= (r_s2.f3[1:0] == F3_MUL[1:0]) ? r_s2_prod[XLEN-1:0]
                                                   : r_s2_prod[2*XLEN-1:XLEN];
      end
      if (flush_i) r_s3.valid <= 1'b0;
    end
  end

  assign mul_if.cdb_req_o  = r_s3.valid;
  assign mul_if.cdb_tag_o  = r_s3.valid ? r_s3.prd  : '0;
  assign mul_if.cdb_data_o = r_s3.valid ? r_s3_data : '0;
  assign mul_if.cdb_pc_o   = r_s3.valid ? r_s3.pc   : '0;

  // Source tags and the rest of the instruction word are debug-only here.
  assign w_unused = ^{mul_if.mul_prs1_addr_i, mul_if.mul_prs2_addr_i,
                      mul_if.mul_inst_i[31:15], mul_if.mul_inst_i[11:0],
                      w_prod[2*XLEN+1:2*XLEN], r_s3.f3};

  // The RS must never issue while the unit is not ready; such a request is dropped.
  a_no_issue_when_busy: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mul_if.mul_request_i && !mul_if.mul_ready_o))
    else $warning("mul_fu: issue while not ready was dropped");

endmodule
